// File: rtl/single_bus_pkg.sv
// Shared definitions for the two-master single-bus arbiter.
// Holds the sequencer state encoding, the chip-select address prefixes,
// the master index constants and the round-robin pick helper.
package single_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2
    } arb_state_e;

    // Address prefixes compared against the top bits of the granted address.
    localparam logic [0:0] CS_ROM_PREFIX = 1'b1;
    localparam logic [1:0] CS_RAM_PREFIX = 2'b01;
    localparam logic [2:0] CS_IO_PREFIX  = 3'b001;

    localparam logic MST_M0 = 1'b0;
    localparam logic MST_M1 = 1'b1;

    // Winner of an arbitration round: a lone requester wins outright, a tie
    // goes to the master that was not served last.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return ~last;
        end
        return req1;
    endfunction

endpackage

// File: rtl/single_bus_addr_decode.sv
// Chip-select decoder for the shared bus.
// Purely combinational; looks only at the three most significant address bits.
// Ports:
//   addr_msb_i  top three bits of the granted slave address
//   rom_cs_o    ROM select  (prefix 1)
//   ram_cs_o    RAM select  (prefix 01)
//   io_cs_o     PIO select  (prefix 001)
// Prefix 000 is unmapped and selects nothing.
module single_bus_addr_decode
    import single_bus_pkg::*;
(
    input  logic [2:0] addr_msb_i,
    output logic       rom_cs_o,
    output logic       ram_cs_o,
    output logic       io_cs_o
);

    assign rom_cs_o = (addr_msb_i[2 -: 1] == CS_ROM_PREFIX);
    assign ram_cs_o = (addr_msb_i[2 -: 2] == CS_RAM_PREFIX);
    assign io_cs_o  = (addr_msb_i[2 -: 3] == CS_IO_PREFIX);

endmodule

// File: rtl/single_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the shared program/data bus.
// One transaction at a time; reads get an extra wait cycle when the slaves
// are synchronous (READ_LATENCY=1). The granted address is decoded into
// ROM/RAM/PIO chip selects.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   m0_*/m1_*                  master request, address, write data, strobes,
//                              read data and single-cycle ack
//   s_addr, s_wdata, s_write_* granted request towards the slaves
//   s_rdata                    OR-combined slave read data
//   rom_cs, ram_cs, io_cs      chip selects
//   m0_lock, m1_lock           bus lock, only with SINGLE_BUS_ARB_LOCK_EN defined
// Build option: SINGLE_BUS_ARB_LOCK_EN lets a locking owner keep the bus at
// transaction completion even while the other master is waiting.
module single_bus_arbiter
    import single_bus_pkg::*;
#(
    parameter int ADDR_BUS_WIDTH = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int READ_LATENCY   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m0_req,
    input  logic [ADDR_BUS_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0]     m0_wdata,
    input  logic                      m0_write_w,
    input  logic                      m0_write_h,
    input  logic                      m0_write_b,
    output logic [DATA_WIDTH-1:0]     m0_rdata,
    output logic                      m0_ack,
    input  logic                      m1_req,
    input  logic [ADDR_BUS_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0]     m1_wdata,
    input  logic                      m1_write_w,
    input  logic                      m1_write_h,
    input  logic                      m1_write_b,
    output logic [DATA_WIDTH-1:0]     m1_rdata,
    output logic                      m1_ack,
    output logic [ADDR_BUS_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0]     s_wdata,
    output logic                      s_write_w,
    output logic                      s_write_h,
    output logic                      s_write_b,
    input  logic [DATA_WIDTH-1:0]     s_rdata,
    output logic                      rom_cs,
    output logic                      ram_cs,
    output logic                      io_cs
`ifdef SINGLE_BUS_ARB_LOCK_EN
    ,
    input  logic                      m0_lock,
    input  logic                      m1_lock
`endif
);

    arb_state_e state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_q, last_d;

    logic                      own_req, oth_req, own_lock, own_write;
    logic [ADDR_BUS_WIDTH-1:0] own_addr;
    logic [DATA_WIDTH-1:0]     own_wdata;
    logic [2:0]                own_strb;
    logic                      drive, done, arb;

    always_comb begin
        own_req   = owner_q ? m1_req : m0_req;
        oth_req   = owner_q ? m0_req : m1_req;
        own_addr  = owner_q ? m1_addr : m0_addr;
        own_wdata = owner_q ? m1_wdata : m0_wdata;
        own_strb  = owner_q ? {m1_write_w, m1_write_h, m1_write_b}
                            : {m0_write_w, m0_write_h, m0_write_b};
        own_write = |own_strb;
`ifdef SINGLE_BUS_ARB_LOCK_EN
        own_lock  = owner_q ? m1_lock : m0_lock;
`else
        own_lock  = 1'b0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        drive     = 1'b0;
        done      = 1'b0;
        arb       = 1'b0;
        s_write_w = 1'b0;
        s_write_h = 1'b0;
        s_write_b = 1'b0;

        case (state_q)
            ST_IDLE: arb = 1'b1;
            ST_ACCESS: begin
                // Owner kept after completion but has since dropped its request:
                // this cycle behaves as IDLE so a waiting master is not delayed further.
                if (!own_req) begin
                    arb = 1'b1;
                end else begin
                    drive = 1'b1;
                    if (own_write) begin
                        {s_write_w, s_write_h, s_write_b} = own_strb;
                        done = 1'b1;
                    end else if (READ_LATENCY == 0) begin
                        done = 1'b1;
                    end else begin
                        state_d = ST_RDWAIT;
                    end
                end
            end
            ST_RDWAIT: begin
                drive = 1'b1;
                done  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (arb) begin
            if (m0_req || m1_req) begin
                owner_d = rr_pick(m0_req, m1_req, last_q);
                state_d = ST_ACCESS;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (done) begin
            last_d = owner_q;
            if (own_req && own_lock) begin
                state_d = ST_ACCESS;
            end else if (oth_req) begin
                owner_d = ~owner_q;
                state_d = ST_ACCESS;
            end else if (own_req) begin
                state_d = ST_ACCESS;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= MST_M0;
            last_q  <= MST_M1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    assign s_addr  = drive ? own_addr : '0;
    assign s_wdata = drive ? own_wdata : '0;

    // A completion coinciding with reset is abandoned, so no ack escapes.
    assign m0_ack   = done & ~rst & (owner_q == MST_M0);
    assign m1_ack   = done & ~rst & (owner_q == MST_M1);
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

    single_bus_addr_decode u_decode (
        .addr_msb_i (s_addr[ADDR_BUS_WIDTH-1 -: 3]),
        .rom_cs_o   (rom_cs),
        .ram_cs_o   (ram_cs),
        .io_cs_o    (io_cs)
    );

endmodule
